i2c_slave: RTL and testbench

Byte-oriented I2C target that sits on the far side of the SDA/SCL bus from `i2c_master`. It answers to one 7-bit address, ACKs each write and delivers every received byte on a one-cycle strobe. For reads it serializes a byte supplied by the local side and accepts multi-byte transfers and repeated START. SCL and SDA are oversampled on the local system clock; the block never stretches SCL.

---
 rtl/i2c_slave.sv | 248 ++++++++++++++++++++++++
 tb/tb_i2c_slave.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave.sv
// I2C target at SLAVE_ADDR: oversampled SCL/SDA, ACKs writes, serializes reads, never stretches SCL.
// Define I2C_SLAVE_GLITCH_FILTER_EN to add a 3-sample stability filter on both synchronized lines.
module i2c_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h42
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i2c_scl,
  inout  wire        i2c_sda,
  input  logic [7:0] tx_data,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       tx_ack,
  output logic       busy,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_ADDR      = 4'd1,
    S_ADDR_ACK  = 4'd2,
    S_RX_DATA   = 4'd3,
    S_RX_ACK    = 4'd4,
    S_TX_DATA   = 4'd5,
    S_TX_ACK    = 4'd6,
    S_WAIT_STOP = 4'd7
  } state_t;

  logic [1:0] r_scl_sync;
  logic [1:0] r_sda_sync;
  logic       w_scl;
  logic       w_sda;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_scl_sync <= 2'b11;
      r_sda_sync <= 2'b11;
    end else begin
      r_scl_sync <= {r_scl_sync[0], i2c_scl};
      r_sda_sync <= {r_sda_sync[0], i2c_sda};
    end
  end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
  logic [2:0] r_scl_hist;
  logic [2:0] r_sda_hist;
  logic       r_scl_filt;
  logic       r_sda_filt;

  // Output follows a line only once three consecutive samples agree.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_scl_hist <= 3'b111;
      r_sda_hist <= 3'b111;
      r_scl_filt <= 1'b1;
      r_sda_filt <= 1'b1;
    end else begin
      r_scl_hist <= {r_scl_hist[1:0], r_scl_sync[1]};
      r_sda_hist <= {r_sda_hist[1:0], r_sda_sync[1]};
      if (&r_scl_hist)
        r_scl_filt <= 1'b1;
      else if (~|r_scl_hist)
        r_scl_filt <= 1'b0;
      if (&r_sda_hist)
        r_sda_filt <= 1'b1;
      else if (~|r_sda_hist)
        r_sda_filt <= 1'b0;
    end
  end

  assign w_scl = r_scl_filt;
  assign w_sda = r_sda_filt;
`else
  assign w_scl = r_scl_sync[1];
  assign w_sda = r_sda_sync[1];
`endif

  logic r_scl_prev;
  logic r_sda_prev;
  logic w_scl_rise;
  logic w_scl_fall;
  logic w_start;
  logic w_stop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_scl_prev <= 1'b1;
      r_sda_prev <= 1'b1;
    end else begin
      r_scl_prev <= w_scl;
      r_sda_prev <= w_sda;
    end
  end

  assign w_scl_rise = w_scl & ~r_scl_prev;
  assign w_scl_fall = ~w_scl & r_scl_prev;
  assign w_start    = w_scl & r_scl_prev & r_sda_prev & ~w_sda;
  assign w_stop     = w_scl & r_scl_prev & ~r_sda_prev & w_sda;

  state_t     r_state;
  logic [2:0] r_bit_cnt;
  logic [6:0] r_rx_shift;
  logic [6:0] r_tx_shift;
  logic       r_rw;
  logic       r_ack_drv;
  logic       r_tx_last;
  logic       r_tx_load;
  logic       r_sda_oe;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_bit_cnt  <= 3'd7;
      r_rx_shift <= 7'd0;
      r_tx_shift <= 7'd0;
      r_rw       <= 1'b0;
      r_ack_drv  <= 1'b0;
      r_tx_last  <= 1'b0;
      r_tx_load  <= 1'b0;
      r_sda_oe   <= 1'b0;
      rx_data    <= 8'd0;
      rx_valid   <= 1'b0;
      tx_ack     <= 1'b0;
      busy       <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      tx_ack   <= 1'b0;
      if (w_start) begin
        r_state   <= S_ADDR;
        r_bit_cnt <= 3'd7;
        r_sda_oe  <= 1'b0;
        r_ack_drv <= 1'b0;
        r_tx_last <= 1'b0;
        r_tx_load <= 1'b0;
      end else if (w_stop) begin
        r_state   <= S_IDLE;
        r_sda_oe  <= 1'b0;
        busy      <= 1'b0;
        r_ack_drv <= 1'b0;
        r_tx_last <= 1'b0;
        r_tx_load <= 1'b0;
      end else begin
        case (r_state)
          S_ADDR: begin
            if (w_scl_rise) begin
              r_rx_shift <= {r_rx_shift[5:0], w_sda};
              r_bit_cnt  <= r_bit_cnt - 3'd1;
              if (r_bit_cnt == 3'd0) begin
                r_rw <= w_sda;
                if (r_rx_shift == SLAVE_ADDR) begin
                  r_state <= S_ADDR_ACK;
                  busy    <= 1'b1;
                end else begin
                  r_state <= S_WAIT_STOP;
                  busy    <= 1'b0;
                end
              end
            end
          end
          S_ADDR_ACK: begin
            if (w_scl_fall) begin
              if (!r_ack_drv) begin
                r_sda_oe  <= 1'b1;
                r_ack_drv <= 1'b1;
              end else begin
                r_ack_drv <= 1'b0;
                r_bit_cnt <= 3'd7;
                if (r_rw) begin
                  r_tx_shift <= tx_data[6:0];
                  r_sda_oe   <= ~tx_data[7];
                  tx_ack     <= 1'b1;
                  r_state    <= S_TX_DATA;
                end else begin
                  r_sda_oe <= 1'b0;
                  r_state  <= S_RX_DATA;
                end
              end
            end
          end
          S_RX_DATA: begin
            if (w_scl_rise) begin
              r_rx_shift <= {r_rx_shift[5:0], w_sda};
              r_bit_cnt  <= r_bit_cnt - 3'd1;
              if (r_bit_cnt == 3'd0) begin
                rx_data  <= {r_rx_shift, w_sda};
                rx_valid <= 1'b1;
                r_state  <= S_RX_ACK;
              end
            end
          end
          S_RX_ACK: begin
            if (w_scl_fall) begin
              if (!r_ack_drv) begin
                r_sda_oe  <= 1'b1;
                r_ack_drv <= 1'b1;
              end else begin
                r_sda_oe  <= 1'b0;
                r_ack_drv <= 1'b0;
                r_bit_cnt <= 3'd7;
                r_state   <= S_RX_DATA;
              end
            end
          end
          S_TX_DATA: begin
            // A pending reload comes from a master ACK; the byte starts on the next fall.
            if (w_scl_fall) begin
              if (r_tx_load) begin
                r_tx_load  <= 1'b0;
                r_tx_shift <= tx_data[6:0];
                r_sda_oe   <= ~tx_data[7];
                tx_ack     <= 1'b1;
                r_bit_cnt  <= 3'd7;
              end else if (r_tx_last) begin
                r_tx_last <= 1'b0;
                r_sda_oe  <= 1'b0;
                r_state   <= S_TX_ACK;
              end else begin
                r_sda_oe   <= ~r_tx_shift[6];
                r_tx_shift <= {r_tx_shift[5:0], 1'b0};
              end
            end else if (w_scl_rise && !r_tx_load) begin
              r_bit_cnt <= r_bit_cnt - 3'd1;
              if (r_bit_cnt == 3'd0)
                r_tx_last <= 1'b1;
            end
          end
          S_TX_ACK: begin
            if (w_scl_rise) begin
              if (w_sda) begin
                r_state <= S_WAIT_STOP;
              end else begin
                r_state   <= S_TX_DATA;
                r_tx_load <= 1'b1;
              end
            end
          end
          S_WAIT_STOP: r_sda_oe <= 1'b0;
          S_IDLE:      r_sda_oe <= 1'b0;
          default:     r_state  <= S_IDLE;
        endcase
      end
    end
  end

  assign i2c_sda = r_sda_oe ? 1'b0 : 1'bz;
  assign state   = r_state;

endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: bit-banged bus master, transaction-level reference model, strobe scoreboard.
module tb_i2c_slave;

  localparam int HP = 100;

  logic       clk;
  logic       rst;
  logic       scl;
  logic       m_low;
  logic [7:0] tx_data;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_ack;
  logic       busy;
  logic [3:0] state;
  wire        sda;

  pullup (sda);
  assign sda = m_low ? 1'b0 : 1'bz;

  int         n_tests;
  int         n_fail;
  int         silent_viol;
  logic       expect_silent;
  logic [7:0] exp_rx[$];
  logic [7:0] exp_txcap[$];

  i2c_slave #(.SLAVE_ADDR(7'h42)) dut (
    .clk      (clk),
    .rst      (rst),
    .i2c_scl  (scl),
    .i2c_sda  (sda),
    .tx_data  (tx_data),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_ack   (tx_ack),
    .busy     (busy),
    .state    (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Pops the scoreboard on every strobe and feeds the local tx byte source.
  task automatic monitor();
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (rx_valid) begin
        if (exp_rx.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL rx_valid_unexpected: got strobe with rx_data=%02h, required none", rx_data);
        end else begin
          e = exp_rx.pop_front();
          check("rx_data", {24'd0, rx_data}, {24'd0, e});
        end
      end
      if (tx_ack) begin
        if (exp_txcap.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL tx_ack_unexpected: got strobe, required none");
        end else begin
          e = exp_txcap.pop_front();
          check("tx_msb_on_bus", {31'd0, sda}, {31'd0, e[7]});
        end
      end
      if (expect_silent && !m_low && sda === 1'b0)
        silent_viol++;
      tx_data = (exp_txcap.size() != 0) ? exp_txcap[0] : 8'h00;
    end
  endtask

  task automatic bit_io(input logic b_out, output logic b_in);
    m_low = !b_out;
    #(HP); scl = 1'b1;
    #(HP); b_in = sda;
    #(HP); scl = 1'b0;
    #10;   m_low = 1'b0;
    #(HP - 10);
  endtask

  task automatic glitch_bit(input logic b_out);
    m_low = !b_out;
    #(HP); scl = 1'b1;
    #(HP / 2); scl = 1'b0;
    #20;       scl = 1'b1;
    #(HP / 2 - 20);
    #(HP); scl = 1'b0;
    #10;   m_low = 1'b0;
    #(HP - 10);
  endtask

  task automatic i2c_start();
    m_low = 1'b0;
    #(HP); scl = 1'b1;
    #(HP); m_low = 1'b1;
    #(HP); scl = 1'b0;
    #10;   m_low = 1'b0;
    #(HP - 10);
  endtask

  task automatic i2c_stop();
    m_low = 1'b1;
    #(HP); scl = 1'b1;
    #(HP); m_low = 1'b0;
    #(2 * HP);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic nack);
    logic d;
    for (int i = 7; i >= 0; i--) bit_io(b[i], d);
    bit_io(1'b1, nack);
  endtask

  task automatic read_byte(input logic last, output logic [7:0] b);
    logic d;
    for (int i = 7; i >= 0; i--) begin
      bit_io(1'b1, d);
      b[i] = d;
    end
    bit_io(last, d);
  endtask

  task automatic send_addr(input logic [6:0] a, input logic rw, output logic matched);
    logic nack;
    matched = (a == 7'h42);
    expect_silent = !matched;
    i2c_start();
    write_byte({a, rw}, nack);
    check("addr_ack_bit", {31'd0, nack}, {31'd0, !matched});
    check("busy_after_addr", {31'd0, busy}, {31'd0, matched});
  endtask

  task automatic write_data(input logic matched, input logic [7:0] d[$]);
    logic nack;
    foreach (d[i]) begin
      if (matched) exp_rx.push_back(d[i]);
      write_byte(d[i], nack);
      check("data_ack_bit", {31'd0, nack}, {31'd0, !matched});
    end
  endtask

  task automatic read_data(input logic matched, input logic [7:0] d[$]);
    logic [7:0] got;
    foreach (d[i]) begin
      read_byte(i == d.size() - 1, got);
      if (matched) check("read_byte", {24'd0, got}, {24'd0, d[i]});
    end
  endtask

  task automatic finish_xfer();
    i2c_stop();
    repeat (8) @(negedge clk);
    check("busy_after_stop", {31'd0, busy}, 32'd0);
    check("state_after_stop", {28'd0, state}, 32'd0);
    check("rx_strobes_missing", exp_rx.size(), 32'd0);
    check("tx_acks_missing", exp_txcap.size(), 32'd0);
    check("sda_never_driven", silent_viol, 32'd0);
    silent_viol   = 0;
    expect_silent = 1'b0;
    exp_rx.delete();
    exp_txcap.delete();
  endtask

  // Model: only 0x42 answers; writes echo every byte, reads return the supplied bytes in order.
  task automatic xfer(input logic [6:0] a, input logic rw, input logic [7:0] d[$], input logic do_stop);
    logic matched;
    if (rw && a == 7'h42)
      foreach (d[i]) exp_txcap.push_back(d[i]);
    send_addr(a, rw, matched);
    if (rw) read_data(matched, d);
    else    write_data(matched, d);
    check("state_after_last_byte", {28'd0, state}, (matched && !rw) ? 32'd3 : 32'd7);
    if (do_stop) finish_xfer();
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] q[$];
    logic [7:0] aw;
    logic [6:0] a;
    logic       rw;
    logic       d;
    logic       nack;
    logic       g_match;
    int         n;

    n_tests       = 0;
    n_fail        = 0;
    silent_viol   = 0;
    expect_silent = 1'b0;
    rst           = 1'b1;
    scl           = 1'b1;
    m_low         = 1'b0;
    fork
      monitor();
    join_none

    repeat (3) @(negedge clk);
    check("reset_state", {28'd0, state}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_rx_data", {24'd0, rx_data}, 32'd0);
    check("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("reset_tx_ack", {31'd0, tx_ack}, 32'd0);
    check("reset_sda", {31'd0, sda}, 32'd1);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    q.delete(); q.push_back(8'hA5);
    xfer(7'h42, 1'b0, q, 1'b1);
    xfer(7'h43, 1'b0, q, 1'b1);

    q.delete(); q.push_back(8'h3C);
    xfer(7'h42, 1'b1, q, 1'b1);

    q.delete(); q.push_back(8'h11); q.push_back(8'h22);
    xfer(7'h42, 1'b0, q, 1'b0);
    q.delete(); q.push_back(8'h5A); q.push_back(8'h96);
    xfer(7'h42, 1'b1, q, 1'b1);

    // STOP after four address bits.
    aw = 8'h84;
    i2c_start();
    for (int i = 7; i >= 4; i--) bit_io(aw[i], d);
    finish_xfer();

    // Reset while the address ACK is being driven.
    i2c_start();
    for (int i = 7; i >= 0; i--) bit_io(aw[i], d);
    check("ack_driven_before_reset", {31'd0, sda}, 32'd0);
    rst = 1'b1;
    #1;
    check("sda_released_on_reset", {31'd0, sda}, 32'd1);
    check("state_on_reset", {28'd0, state}, 32'd0);
    #9;
    rst = 1'b0;
    bit_io(1'b1, d);
    check("ninth_bit_after_reset", {31'd0, d}, 32'd1);
    finish_xfer();

    // Short SCL low glitch in the fourth address bit.
`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    g_match = 1'b1;
`else
    g_match = 1'b0;
`endif
    expect_silent = !g_match;
    i2c_start();
    for (int i = 7; i >= 0; i--) begin
      if (i == 4) glitch_bit(aw[i]);
      else        bit_io(aw[i], d);
    end
    bit_io(1'b1, nack);
    check("glitch_addr_ack_bit", {31'd0, nack}, {31'd0, !g_match});
    check("glitch_busy", {31'd0, busy}, {31'd0, g_match});
    q.delete(); q.push_back(8'($urandom_range(0, 255)));
    write_data(g_match, q);
    finish_xfer();

    for (int t = 0; t < 10; t++) begin
      a  = ($urandom_range(0, 2) != 0) ? 7'h42 : 7'($urandom_range(0, 127));
      rw = 1'($urandom_range(0, 1));
      n  = $urandom_range(1, 3);
      q.delete();
      for (int k = 0; k < n; k++) q.push_back(8'($urandom_range(0, 255)));
      xfer(a, rw, q, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
